// File: rtl/uart_pkg.sv
// Shared definitions for the UART: register map, status bit positions and
// the state encoding used by both the transmit and receive sequencers.
package uart_pkg;

    localparam logic [3:0] UART_DATA = 4'd0;
    localparam logic [3:0] UART_STAT = 4'd1;
    localparam logic [3:0] UART_IE   = 4'd2;
    localparam logic [3:0] UART_DIV  = 4'd3;

    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_RX_FULL     = 1;
    localparam int unsigned ST_TX_EMPTY    = 2;
    localparam int unsigned ST_TX_FULL     = 3;
    localparam int unsigned ST_TX_BUSY     = 4;
    localparam int unsigned ST_RX_OVF      = 5;
    localparam int unsigned ST_FRAME_ERR   = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with wrap-bit pointers; head is presented combinationally.
module uart_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    // A same-cycle pop frees the head slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart.sv
// 8N1 UART with TX/RX byte FIFOs on a 16-bit register bus and a level
// interrupt built from the enabled status causes.
module uart
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write,
    input  logic        io_read,
    input  logic [3:0]  io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic        rx,
    output logic        tx,
    output logic        uart_intr
);

    logic [15:0] div_q, div_d;
    logic [2:0]  ie_q, ie_d;
    logic        ovf_q, ovf_d, ferr_q, ferr_d;

    fsm_state_e  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_q, tx_d, tx_pop;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    fsm_state_e  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_push, ovf_set, ferr_set;

    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;
    logic        wr_data, wr_stat, wr_ie, wr_div, rx_pop;
    logic [6:0]  status;

    assign wr_data = io_write && (io_addr == UART_DATA) && !tx_full;
    assign wr_stat = io_write && (io_addr == UART_STAT);
    assign wr_ie   = io_write && (io_addr == UART_IE);
    assign wr_div  = io_write && (io_addr == UART_DIV);
    assign rx_pop  = io_read && (io_addr == UART_DATA) && !rx_empty;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_data),
        .data_i  (io_wdata[7:0]),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_head)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .data_i  (rx_sh_q),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_cnt_d   = div_q;
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_d       = tx_sh_q[0];
                    tx_sh_d    = tx_sh_q >> 1;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    // Chain straight into the next start bit so queued frames leave no gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_d    = tx_head;
                        tx_cnt_d   = div_q;
                        tx_d       = 1'b0;
                        tx_state_d = S_START;
                    end else begin
                        tx_d       = 1'b1;
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        ovf_set    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = div_q >> 1;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_cnt_d   = div_q;
                        rx_bit_d   = '0;
                        rx_state_d = S_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = div_q;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    if (!rx_s2_q)                 ferr_set = 1'b1;
                    else if (!rx_full || rx_pop)  rx_push  = 1'b1;
                    else                          ovf_set  = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d  = wr_div ? io_wdata : div_q;
        ie_d   = wr_ie ? io_wdata[2:0] : ie_q;
        ovf_d  = (ovf_q  && !(wr_stat && io_wdata[5])) || ovf_set;
        ferr_d = (ferr_q && !(wr_stat && io_wdata[6])) || ferr_set;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= DIV_RESET;
            ie_q       <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            div_q      <= div_d;
            ie_q       <= ie_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_BUSY]     = (tx_state_q != S_IDLE);
        status[ST_RX_OVF]      = ovf_q;
        status[ST_FRAME_ERR]   = ferr_q;
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            UART_DATA: io_rdata = rx_empty ? '0 : {8'h00, rx_head};
            UART_STAT: io_rdata = {9'h000, status};
            UART_IE:   io_rdata = {13'h0000, ie_q};
            UART_DIV:  io_rdata = div_q;
            default:   io_rdata = '0;
        endcase
    end

    assign tx        = tx_q;
    assign uart_intr = |(ie_q & {ovf_q | ferr_q, tx_empty, !rx_empty});

endmodule

// File: doc/uart.md
# uart

Byte-serial 8N1 UART with small transmit and receive FIFOs on the 16-bit I/O bus. It generates the `uart_intr` level consumed by the interrupt controller as pending source 0. Software sets the baud divisor, pushes TX bytes, pops RX bytes, and enables three interrupt causes. `uart_intr` is the OR of the enabled causes.

## Interface
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `DIV_RESET`, 16'd433: divisor value at reset.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low; `reset==0` at a `clk` edge resets the block.
- `io_write`  in  1  write strobe; one write per cycle.
- `io_read`  in  1  read strobe; only side effect is the RX pop at address 0.
- `io_addr`  in  4  register select.
- `io_wdata`  in  16  write data.
- `io_rdata`  out  16  combinational read data; 0 for unmapped addresses.
- `rx`  in  1  serial input, asynchronous.
- `tx`  out  1  serial output; idles high.
- `uart_intr`  out  1  level interrupt.

## Operation
- **Addr 0**
  - Write pushes `io_wdata[7:0]` into the TX FIFO. The byte is silently dropped if the FIFO is full.
  - Read returns `{8'h0, rx_head}`. With `io_read`, it pops if non-empty. With the FIFO empty it returns 0 and pops nothing.
- **Addr 1, status**
  - Read returns `{9'h0, frame_err, rx_ovf, tx_busy, tx_full, tx_empty, rx_full, rx_nonempty}`, bits 6..0.
  - Write-1-to-clear: `io_wdata[5]` clears `rx_ovf`, `io_wdata[6]` clears `frame_err`.
- **Addr 2**: `ie[2:0]`, r/w. Bit 0 = rx_nonempty, bit 1 = tx_empty, bit 2 = rx_ovf | frame_err.
- **Addr 3**: divisor, 16-bit r/w. Bit period is `divisor+1` clocks. Divisor values below 3 are unsupported.
- `uart_intr = |(ie & {rx_ovf|frame_err, tx_empty, rx_nonempty})`, driven only from flops.
- **TX FSM** (IDLE, START, DATA, STOP)
  - IDLE with FIFO non-empty: pop into shift register, go to START with `tx=0`.
  - DATA shifts 8 bits, LSB first. STOP drives 1 for one bit period, then returns to IDLE.
  - `tx_busy = state!=IDLE`.
- **RX**: `rx` passes through a 2-flop synchronizer. RX FSM states are IDLE, START, DATA, STOP.
  - IDLE: a falling sample loads the bit counter with `divisor>>1`, go to START.
  - START: on count 0, resample. High means a false start; return to IDLE with no flag. Low reloads `divisor` and goes to DATA.
  - DATA: sample 8 bits at mid-bit, one every `divisor+1` clocks.
  - STOP: sample the stop bit.
    - 1 and FIFO not full: push the byte.
    - 1 and FIFO full: set `rx_ovf`, discard the byte.
    - 0: set `frame_err`, discard the byte.
  - Return to IDLE immediately after the stop sample.
- **Simultaneous events**
  - RX push and software pop on a full FIFO in the same cycle: both happen, no overflow.
  - Hardware flag set and software clear in the same cycle: the set wins.
- Divisor writes take effect at the next counter reload; an in-flight bit completes at the old rate.

## Timing
- **Reset values**: `tx=1`, both FIFOs empty, both FSMs IDLE, `ie=0`, `rx_ovf=0`, `frame_err=0`, divisor=`DIV_RESET`.
  - `uart_intr=0`, since `ie=0`.
  - Status reads 16'h0004.
- **Reset mid-frame**: next cycle `tx=1` and all FIFO contents are lost.
- **TX latency**: write to an empty FIFO with TX idle at cycle N. The FIFO is non-empty at N+1 and `tx` goes low at N+2.
  - A frame lasts exactly `10*(divisor+1)` clocks.
  - Back-to-back frames have no idle gap.
- **RX latency**: 2-cycle synchronizer. The stop-bit sample edge pushes the byte; `rx_nonempty`, `rx_ovf` and `frame_err` are visible the following cycle.
- **Pop**: read-pop at cycle N updates the head and status at N+1. `uart_intr` falls at N+1 if the FIFO is emptied.
- `io_rdata` is combinational off `io_addr` with zero cycles of latency.

## Structure
- **Package `uart_pkg`**: register addresses (`UART_DATA=0`, `UART_STAT=1`, `UART_IE=2`, `UART_DIV=3`), status bit indices, and a 2-bit state enum shared by the TX and RX FSMs.
- **Sub-module `uart_fifo`**: parameterised by depth, width 8. Ports are push/pop/full/empty/head, with `ptr+1`-bit wrap-around pointers. It is instantiated twice.

## Test plan
- **Reset**: hold `reset=0` for 2 cycles, then release.
  - `tx=1`, `uart_intr=0`.
  - Status reads 16'h0004 and addr 3 reads `DIV_RESET`.
- **TX waveform**: divisor=3, write 0x55.
  - `tx` low for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks.
  - `tx_busy` is high for exactly 40 clocks.
- **Loopback**: `tx` tied to `rx`, divisor=3, ie=1, send 0xA5.
  - `uart_intr` rises after the stop sample.
  - Addr 0 with `io_read` reads 16'h00A5, and `uart_intr` falls the next cycle.
- **Overflow**: FIFO_DEPTH=4, send 5 bytes 0x01..0x05 unread.
  - `rx_ovf` is set.
  - Reads return 0x01..0x04, then 0.
  - Writing 16'h0020 to addr 1 clears `rx_ovf`.
- **Framing**: drive a frame with stop bit 0, ie=4.
  - `frame_err` is set, the FIFO stays empty and `uart_intr=1`.
  - A separate 1-clock low glitch on `rx` produces no byte and no flag.
- **Reset mid-frame**: assert reset halfway through a TX byte.
  - `tx=1` on the next cycle.
  - After release, status reads 16'h0004.
